// File: rtl/store_narrow_unit.sv
// store_narrow_unit
// Narrows a 32-bit register value to a byte, halfword or word store. It puts
// the value on the little-endian byte lanes, drives byte enables and runs a
// req/ack write handshake with an optional timeout. Misaligned and illegal
// stores are rejected with a fault pulse, and the memory port is never touched
// for them.
module store_narrow_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        fault,
  output logic        bus_err,
  output logic [31:0] fault_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // A timeout of zero turns the watchdog off, so the counter compare is then unused.
  localparam bit              TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic bad_store;
  logic ack_hit;
  logic limit_hit;

  // Returns 1 when the store cannot be issued: the size code is illegal or
  // the address is not a multiple of the access size.
  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    f = 1'b0;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = off[0];
      SZ_WORD: f = |off;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Replicates the narrowed value across every lane. The memory then picks the
  // lanes through the byte enables, so the data does not depend on the offset.
  function automatic logic [31:0] narrow_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    w = data;
    case (size)
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Byte-enable mask. Bit i selects lane i (bits 8i+7:8i).
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Decode of the handshake events for the current cycle.
  always_comb begin
    accept    = st_valid && st_ready && (state == IDLE);
    bad_store = is_fault(st_size, st_addr[1:0]);
    ack_hit   = (state == REQ) && mem_ack;
    limit_hit = TO_EN && (state == REQ) && !mem_ack && (cnt == LIMIT);
  end

  // Control path: FSM state, ready, request, timeout counter and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      st_ready <= 1'b0;
      mem_req  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      fault   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!st_ready) begin
            st_ready <= 1'b1;
          end else if (accept) begin
            if (bad_store) begin
              fault <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              st_ready <= 1'b0;
              cnt      <= '0;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (ack_hit) begin
            mem_req  <= 1'b0;
            done     <= 1'b1;
            st_ready <= 1'b1;
            state    <= IDLE;
          end else if (limit_hit) begin
            mem_req  <= 1'b0;
            bus_err  <= 1'b1;
            st_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mem_req  <= 1'b0;
          st_ready <= 1'b0;
        end
      endcase
    end
  end

  // Memory-port payload. It is loaded on a legal accept and held through REQ,
  // and the byte enables are cleared when the transaction ends either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (accept && !bad_store) begin
      mem_addr  <= {st_addr[31:2], 2'b00};
      mem_wdata <= narrow_wdata(st_size, st_data);
      mem_be    <= lane_be(st_size, st_addr[1:0]);
    end else if (ack_hit || limit_hit) begin
      mem_be    <= '0;
    end
  end

  // Address of the most recent rejected store, kept for the trap handler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_addr <= '0;
    end else if (accept && bad_store) begin
      fault_addr <= st_addr;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Testbench for store_narrow_unit. The driver pushes expected memory writes
// and outcomes into queues. A memory responder acks after a programmable
// delay, and a monitor pops and compares on every request start and every
// result pulse.
module tb_store_narrow_unit;

  localparam int TO = 4;

  localparam int K_DONE = 1;
  localparam int K_FLT  = 2;
  localparam int K_BERR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        fault;
  logic        bus_err;
  logic [31:0] fault_addr;

  store_narrow_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .done(done), .fault(fault),
    .bus_err(bus_err), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_t;

  typedef struct {
    int          kind;
    logic [31:0] faddr;
    int          len;
  } evt_t;

  mem_t exp_mem[$];
  evt_t exp_evt[$];
  int   ack_q[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  bit  idle_noise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the store occupies nb consecutive lanes starting at the
  // byte offset, and lane i carries data byte (i mod nb).
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       output bit legal, output mem_t m);
    int nb;
    int off;
    nb  = 1 << s;
    off = int'(a % 4);
    legal = (s != 2'b11) && ((a % nb) == 0);
    m.addr  = a - (a % 4);
    m.wdata = '0;
    m.be    = '0;
    for (int i = 0; i < 4; i++) begin
      m.wdata[8*i +: 8] = d[8*(i % nb) +: 8];
      if (i >= off && i < off + nb) m.be[i] = 1'b1;
    end
  endtask

  // Issue one store starting at a falling edge. It returns at the falling edge
  // after the accepting rising edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int ack_at, input bit keep, input bit no_outcome);
    int   n;
    bit   legal;
    mem_t m;
    evt_t e;
    n = 0;
    while (st_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL ready_wait: got st_ready=%b expected 1 within 100 cycles", st_ready);
        $fatal(1, "st_ready never rose");
      end
    end
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    model(a, d, s, legal, m);
    if (legal) begin
      exp_mem.push_back(m);
      ack_q.push_back(ack_at);
      if (!no_outcome) begin
        e.faddr = '0;
        if (ack_at >= 1 && ack_at <= TO) begin
          e.kind = K_DONE;
          e.len  = ack_at;
        end else begin
          e.kind = K_BERR;
          e.len  = TO;
        end
        exp_evt.push_back(e);
      end
    end else begin
      e.kind  = K_FLT;
      e.faddr = a;
      e.len   = 0;
      exp_evt.push_back(e);
    end
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    if (!keep) st_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_evt.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outcomes_left", exp_evt.size(), 0);
    chk("drain_writes_left", exp_mem.size(), 0);
  endtask

  // Memory responder: acks in the ack_at-th cycle of a request (0 = never).
  // Between requests it may toggle mem_ack at random, which the unit must ignore.
  int req_cycles = 0;
  int cur_ack_at = 0;
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (req_cycles == 0) cur_ack_at = (ack_q.size() != 0) ? ack_q.pop_front() : 1;
      req_cycles++;
      mem_ack = (cur_ack_at != 0) && (req_cycles == cur_ack_at);
    end else begin
      req_cycles = 0;
      mem_ack = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: checks each request payload against the model and its stability,
  // and checks each result pulse against the expected outcome.
  bit   prev_req = 1'b0;
  int   req_len = 0;
  mem_t cap;
  always @(negedge clk) begin
    mem_t m;
    evt_t e;
    int   np;
    int   kact;
    if (rst_n !== 1'b1) begin
      prev_req = 1'b0;
      req_len  = 0;
    end else begin
      if (mem_req === 1'b1) begin
        chk("ready_low_during_req", st_ready, 1'b0);
        if (!prev_req) begin
          req_len = 1;
          if (exp_mem.size() == 0) begin
            chk("unexpected_mem_req", 1, 0);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_wdata", mem_wdata, m.wdata);
            chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
            cap.addr  = mem_addr;
            cap.wdata = mem_wdata;
            cap.be    = mem_be;
          end
        end else begin
          req_len++;
          chk("hold_addr", mem_addr, cap.addr);
          chk("hold_wdata", mem_wdata, cap.wdata);
          chk("hold_be", {28'd0, mem_be}, {28'd0, cap.be});
        end
      end
      np = int'(done) + int'(fault) + int'(bus_err);
      if (np != 0) begin
        chk("pulse_onehot", np, 1);
        if (exp_evt.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_evt.pop_front();
          kact = done ? K_DONE : (fault ? K_FLT : K_BERR);
          chk("outcome_kind", kact, e.kind);
          chk("ready_at_outcome", st_ready, 1'b1);
          if (e.kind == K_FLT) begin
            chk("fault_addr", fault_addr, e.faddr);
          end else begin
            chk("req_cycles", req_len, e.len);
            chk("be_cleared", {28'd0, mem_be}, 32'd0);
            chk("req_dropped", mem_req, 1'b0);
          end
        end
      end
      prev_req = (mem_req === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;
    logic [1:0]  rs;
    logic [31:0] ra;

    // Reset state
    #12;
    chk("rst_ready", st_ready, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_pulses", {29'd0, done, fault, bus_err}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", st_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_first_edge", st_ready, 1'b1);

    // Byte store at offset 3
    do_store(32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 1, 1'b0, 1'b0);
    chk("byte_addr", mem_addr, 32'h0000_1000);
    chk("byte_wdata", mem_wdata, 32'hEFEF_EFEF);
    chk("byte_be", {28'd0, mem_be}, 32'h8);
    @(negedge clk);
    chk("byte_done_latency", done, 1'b1);

    // Half stores, upper then lower halfword
    do_store(32'h0000_2002, 32'h1234_5678, 2'b01, 1, 1'b0, 1'b0);
    chk("half_hi_be", {28'd0, mem_be}, 32'hC);
    chk("half_wdata", mem_wdata, 32'h5678_5678);
    do_store(32'h0000_2000, 32'h1234_5678, 2'b01, 2, 1'b0, 1'b0);
    chk("half_lo_be", {28'd0, mem_be}, 32'h3);

    // Faults, each followed straight away by the next store
    do_store(32'h0000_0005, 32'hAAAA_5555, 2'b01, 1, 1'b0, 1'b0);
    t0 = acc_cyc;
    do_store(32'h0000_0006, 32'h1111_2222, 2'b10, 1, 1'b0, 1'b0);
    chk("fault_next_accept_spacing", acc_cyc - t0, 1);
    do_store(32'h0000_0000, 32'h3333_4444, 2'b11, 1, 1'b0, 1'b0);
    do_store(32'h0000_0008, 32'hCAFE_F00D, 2'b10, 1, 1'b0, 1'b0);
    drain();
    chk("fault_addr_kept", fault_addr, 32'h0000_0000);

    // Timeout, ack at the limit, ack just past the limit
    do_store(32'h0000_3000, 32'h0BAD_0BAD, 2'b10, 0, 1'b0, 1'b0);
    drain();
    do_store(32'h0000_3004, 32'h600D_600D, 2'b10, TO, 1'b0, 1'b0);
    drain();
    do_store(32'h0000_3008, 32'h5A5A_A5A5, 2'b10, TO + 1, 1'b0, 1'b0);
    drain();

    // Reset while the request is outstanding
    do_store(32'h0000_0100, 32'h0102_0304, 2'b10, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_reset_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", mem_req, 1'b0);
    chk("async_be_clear", {28'd0, mem_be}, 32'd0);
    chk("async_fault_addr_clear", fault_addr, 32'd0);
    @(negedge clk);
    chk("reset_no_done", {30'd0, done, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset_ready_low", st_ready, 1'b0);
    @(negedge clk);
    chk("post_reset_ready", st_ready, 1'b1);
    do_store(32'h0000_0104, 32'h7777_8888, 2'b10, 1, 1'b0, 1'b0);
    drain();

    // Back-to-back word stores with st_valid held and immediate ack
    do_store(32'h0000_4000, 32'h1111_1111, 2'b10, 1, 1'b1, 1'b0);
    t0 = acc_cyc;
    do_store(32'h0000_4004, 32'h2222_2222, 2'b10, 1, 1'b1, 1'b0);
    t1 = acc_cyc;
    chk("b2b_spacing_1", t1 - t0, 2);
    do_store(32'h0000_4008, 32'h3333_3333, 2'b10, 1, 1'b0, 1'b0);
    chk("b2b_spacing_2", acc_cyc - t1, 2);
    drain();

    // Randomized stores with random ack delays and idle ack noise
    idle_noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = (rs == 2'b01) ? {ra[1], 1'b0} : ((rs == 2'b10) ? 2'b00 : ra[1:0]);
      do_store(ra, $urandom, rs, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0);
    end
    st_valid = 1'b0;
    drain();
    idle_noise = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the immediate/load sign-extension path: narrows a 32-bit register value to a byte, halfword or word store.
- Places the narrowed data on the correct little-endian byte lanes with byte enables.
- Drives a req/ack handshake to data memory and flags misaligned or illegal stores.
- Sits between the CPU datapath (MEM stage) and the data memory port.

Parameters:
- TIMEOUT, 16: cycles mem_req may stay high without mem_ack before aborting with bus_err; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- st_valid  input  1  store request from datapath.
- st_ready  output  1  unit can accept a store this cycle.
- st_addr  input  32  byte address of store.
- st_data  input  32  register value; low bits used for byte/half.
- st_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_req  output  1  memory write request.
- mem_ack  input  1  memory accepted write.
- mem_addr  output  32  word-aligned address {st_addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- done  output  1  one-cycle pulse: store completed.
- fault  output  1  one-cycle pulse: misaligned/illegal store rejected.
- bus_err  output  1  one-cycle pulse: timeout abort.
- fault_addr  output  32  st_addr of last faulting store.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, st_ready=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, fault=0, bus_err=0, fault_addr=0, counter=0.
- First rising edge with rst_n high: st_ready becomes 1.
- All outputs are registered.
- States: IDLE, REQ.
- IDLE: accept occurs when st_valid && st_ready at a rising edge.
  - Alignment check: half needs st_addr[0]==0; word needs st_addr[1:0]==0; size 11 always faults; byte never faults.
  - Fault: fault=1 for the next cycle, fault_addr=st_addr, st_ready stays 1, no mem_req, state stays IDLE.
  - Legal store:
    - mem_addr = word-aligned address.
    - Byte: mem_wdata={4{st_data[7:0]}}, mem_be = 4'b0001 << st_addr[1:0].
    - Half: mem_wdata={2{st_data[15:0]}}, mem_be = st_addr[1] ? 1100 : 0011.
    - Word: mem_wdata=st_data, mem_be=1111.
    - mem_req=1, st_ready=0, counter=0, state goes to REQ.
- REQ:
  - mem_req, mem_addr, mem_wdata and mem_be are held stable until completion.
  - On the edge sampling mem_ack=1: mem_req=0, mem_be=0, done=1 for one cycle, st_ready=1, state goes to IDLE.
  - Otherwise the counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with mem_ack=0 on that edge: mem_req=0, mem_be=0, bus_err=1 for one cycle, st_ready=1, state goes to IDLE.
  - mem_ack on the same edge as the timeout limit: ack wins; done is asserted, not bus_err.
- Latency: accept at edge N; mem_req high in cycle N+1.
  - With mem_ack in cycle N+1: done and st_ready high in cycle N+2.
  - Minimum store-to-store spacing is 2 cycles.
- mem_ack sampled in IDLE is ignored.
- st_valid while st_ready=0 is ignored; the datapath must hold the request.
- done, fault and bus_err are mutually exclusive and never asserted for two consecutive cycles from the same request.
- Reset mid-REQ: transaction abandoned; mem_req drops immediately (async); no done or bus_err pulse.
- Upper bits of st_data above the selected size are don't-care and never affect mem_wdata.

Test Plan:
- Byte store: addr=0x0000_1003, data=0xDEAD_BEEF, size=00, ack one cycle after req -> mem_addr=0x0000_1000, mem_wdata=0xEFEF_EFEF, mem_be=1000, done pulses 2 cycles after accept.
- Half store: addr=0x0000_2002, data=0x1234_5678, size=01 -> mem_wdata=0x5678_5678, mem_be=1100; repeat at addr 0x2000 -> mem_be=0011.
- Faults: half at 0x0000_0005 -> fault pulse, fault_addr=0x0000_0005, no mem_req; word at 0x0000_0006 faults; size=11 at 0x0 faults; next legal store is accepted in the following cycle.
- Timeout: TIMEOUT=4, mem_ack held 0 -> mem_req high for exactly 4 cycles, then bus_err pulse, st_ready=1.
  - Repeat with ack arriving in the 4th cycle -> done, no bus_err.
- Reset mid-REQ: word store to 0x100, rst_n low for 2 cycles while mem_req=1 -> mem_req drops asynchronously, no done.
  - After release, st_ready=1 one edge later and a new store completes normally.
- Back-to-back: 3 word stores with st_valid held and immediate ack -> accepts spaced 2 cycles, 3 done pulses, mem_wdata matches each input in order.
